// File: rtl/adc_snapshot.sv
// ADC snapshot buffer: arm, trigger, capture 2**DEPTH_LOG2 samples, read back over Wishbone.
// Define ADC_SNAPSHOT_TIMESTAMP_EN to add a cycle counter latched into TSTAMP (offset 0x8).
module adc_snapshot #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              trig_i,
  output logic              busy_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  localparam logic [CntW-1:0]       DepthCnt  = CntW'(Depth);
  localparam logic [DEPTH_LOG2-1:0] OffCtrl   = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0] OffStatus = DEPTH_LOG2'(1);
`ifdef ADC_SNAPSHOT_TIMESTAMP_EN
  localparam logic [DEPTH_LOG2-1:0] OffTstamp = DEPTH_LOG2'(2);
`endif

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCapture,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            trig_sel_q, trig_sel_d;
  logic            arm_q, arm_d;
  logic            abort_q, abort_d;
  logic            sw_trig_q, sw_trig_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            rd_pend_q, rd_pend_d;
  logic [31:0]     dat_q, dat_d;

  logic [DATA_W-1:0] mem [Depth];
  logic [DATA_W-1:0] ram_rd_q;

  logic                  req;
  logic                  is_buf;
  logic                  ctrl_wr;
  logic                  buf_rd;
  logic                  cap_we;
  logic                  trig_hit;
  logic                  trig_evt;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           ctrl_rd;
  logic [31:0]           status_rd;

`ifdef ADC_SNAPSHOT_TIMESTAMP_EN
  logic [31:0] cyc_cnt_q;
  logic [31:0] tstamp_q;
`endif

  assign word_idx = wb_adr_i[DEPTH_LOG2+1:2];
  assign is_buf   = wb_adr_i[DEPTH_LOG2+2];
  assign ctrl_rd  = {29'b0, trig_sel_q, 2'b0};
  assign status_rd = {16'(count_q), 13'b0, state_q == StCapture, state_q == StArmed,
                      state_q == StDone};
  assign busy_o   = (state_q == StArmed) | (state_q == StCapture);
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;

  // A new access is taken only once the previous one has completed, so a master
  // holding stb through the ack cycle never gets a second response.
  always_comb begin
    req       = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q & ~rd_pend_q;
    ctrl_wr   = 1'b0;
    buf_rd    = 1'b0;
    ack_d     = rd_pend_q;
    err_d     = 1'b0;
    rd_pend_d = 1'b0;
    dat_d     = rd_pend_q ? 32'(ram_rd_q) : 32'h0;
    if (req) begin
      if (is_buf) begin
        if (wb_we_i) begin
          err_d = 1'b1;
        end else begin
          buf_rd    = 1'b1;
          rd_pend_d = 1'b1;
        end
      end else begin
        case (word_idx)
          OffCtrl: begin
            ack_d = 1'b1;
            if (wb_we_i) begin
              ctrl_wr = wb_sel_i[0];
            end else begin
              dat_d = ctrl_rd;
            end
          end
          OffStatus: begin
            if (wb_we_i) begin
              err_d = 1'b1;
            end else begin
              ack_d = 1'b1;
              dat_d = status_rd;
            end
          end
`ifdef ADC_SNAPSHOT_TIMESTAMP_EN
          OffTstamp: begin
            if (wb_we_i) begin
              err_d = 1'b1;
            end else begin
              ack_d = 1'b1;
              dat_d = tstamp_q;
            end
          end
`endif
          default: err_d = 1'b1;
        endcase
      end
    end
  end

  // Abort in the same write suppresses arm.
  always_comb begin
    arm_d      = ctrl_wr & wb_dat_i[0] & ~wb_dat_i[1];
    abort_d    = ctrl_wr & wb_dat_i[1];
    sw_trig_d  = ctrl_wr & wb_dat_i[3];
    trig_sel_d = ctrl_wr ? wb_dat_i[2] : trig_sel_q;
  end

  assign trig_hit = trig_sel_q ? sw_trig_q : trig_i;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    cap_we   = 1'b0;
    trig_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arm_q) begin
          state_d = StArmed;
          count_d = '0;
        end
      end
      StArmed: begin
        if (abort_q) begin
          state_d = StIdle;
        end else if (trig_hit) begin
          trig_evt = 1'b1;
          state_d  = StCapture;
          // The trigger cycle's own sample becomes word 0.
          if (din_valid) begin
            cap_we  = 1'b1;
            count_d = count_q + 1'b1;
            if (count_q + 1'b1 == DepthCnt) begin
              state_d = StDone;
            end
          end
        end
      end
      StCapture: begin
        if (abort_q) begin
          state_d = StIdle;
        end else if (din_valid) begin
          cap_we  = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q + 1'b1 == DepthCnt) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (arm_q) begin
          state_d = StArmed;
          count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= StIdle;
      count_q    <= '0;
      trig_sel_q <= 1'b0;
      arm_q      <= 1'b0;
      abort_q    <= 1'b0;
      sw_trig_q  <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      dat_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      trig_sel_q <= trig_sel_d;
      arm_q      <= arm_d;
      abort_q    <= abort_d;
      sw_trig_q  <= sw_trig_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rd_pend_q  <= rd_pend_d;
      dat_q      <= dat_d;
    end
  end

  // Sample buffer: synchronous RAM, never reset.
  always_ff @(posedge wb_clk_i) begin
    if (cap_we) begin
      mem[count_q[DEPTH_LOG2-1:0]] <= din;
    end
    if (buf_rd) begin
      ram_rd_q <= mem[word_idx];
    end
  end

`ifdef ADC_SNAPSHOT_TIMESTAMP_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cyc_cnt_q <= 32'h0;
      tstamp_q  <= 32'h0;
    end else begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if (trig_evt) begin
        tstamp_q <= cyc_cnt_q;
      end
    end
  end

  logic unused_in;
  assign unused_in = ^{wb_adr_i[31:DEPTH_LOG2+3], wb_adr_i[1:0], wb_dat_i[31:4], wb_sel_i[3:1]};
`else
  logic unused_in;
  assign unused_in = ^{wb_adr_i[31:DEPTH_LOG2+3], wb_adr_i[1:0], wb_dat_i[31:4], wb_sel_i[3:1],
                       trig_evt};
`endif

endmodule

// File: doc/adc_snapshot.md
ADC_SNAPSHOT -- requirements
Module: adc_snapshot

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10: buffer depth is 2**DEPTH_LOG2 32-bit words.
REQ-002 SHALL have parameter DATA_W, default 32: sample width, 1..32, zero-extended on readback.
REQ-003 SHALL have one clock and an asynchronous active-low reset: wb_clk_i  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have wb_rst_n_i  in  1  asynchronous active-low reset.
REQ-005 SHALL have wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone slave strobes from wbs_arbiter.
REQ-006 SHALL have wb_sel_i  in  4  byte enables.
REQ-007 SHALL have wb_adr_i  in  32  byte address; only [DEPTH_LOG2+2:0] decoded.
REQ-008 SHALL have wb_dat_i  in  32 and wb_dat_o  out  32  write/read data.
REQ-009 SHALL have wb_ack_o, wb_err_o  out  1 each  single-cycle completion pulses.
REQ-010 SHALL have din  in  DATA_W  ADC sample, pre-synchronised to wb_clk_i.
REQ-011 SHALL have din_valid  in  1  sample qualifier.
REQ-012 SHALL have trig_i  in  1  external trigger, level sampled each cycle.
REQ-013 SHALL have busy_o  out  1  high in ARMED or CAPTURE.

Function
REQ-014 SHALL map registers: 0x0 CTRL (RW), 0x4 STATUS (RO), 0x8 TSTAMP (RO, only with macro); buffer at bit DEPTH_LOG2+2 set, word index = adr[DEPTH_LOG2+1:2].
REQ-015 SHALL treat CTRL bits: [0] arm (self-clearing pulse), [1] abort (self-clearing), [2] trig_sel (0 = trig_i, 1 = software), [3] sw_trig (self-clearing); written only when wb_sel_i[0]=1; readback returns {29'b0, trig_sel, 2'b0}... i.e. bit 2 only.
REQ-016 SHALL report STATUS: [0] done, [1] armed, [2] capturing, [31:16] sample count (saturates at 2**DEPTH_LOG2, DEPTH_LOG2<=15).
REQ-017 SHALL implement FSM IDLE -> (arm) ARMED -> (trigger) CAPTURE -> (count = depth) DONE; DONE -> (arm) ARMED; abort from ARMED/CAPTURE -> IDLE with count retained.
REQ-018 SHALL write din to buffer[count] and increment count on every din_valid cycle in CAPTURE, and on the trigger cycle itself when din_valid=1 (that sample is word 0).
REQ-019 SHALL clear count and done on entry to ARMED; arm while ARMED or CAPTURE SHALL be ignored.
REQ-020 SHALL give register accesses ack one cycle after cyc&stb, buffer reads ack two cycles after (synchronous RAM); one ack per access.
REQ-021 SHALL pulse wb_err_o instead of wb_ack_o for writes to STATUS, TSTAMP, buffer, or any unmapped register offset; no state change.
REQ-022 SHALL allow buffer reads in any state; contents of unwritten words undefined.
REQ-023 SHALL ignore abort and arm in the same write: abort wins.

Reset
REQ-024 SHALL on wb_rst_n_i low immediately force: FSM IDLE, count 0, done 0, trig_sel 0, wb_ack_o 0, wb_err_o 0, wb_dat_o 0, busy_o 0, TSTAMP 0; buffer contents not cleared.
REQ-025 SHALL, when reset is asserted mid-capture, discard the capture and treat any in-flight bus access as never acked.

Configuration
REQ-026 SHALL, with ADC_SNAPSHOT_TIMESTAMP_EN defined, run a free-running 32-bit wrapping cycle counter and latch it into TSTAMP on the trigger cycle.
REQ-027 SHALL, without ADC_SNAPSHOT_TIMESTAMP_EN, omit the counter; offset 0x8 is unmapped (err on read and write).

Verification
REQ-028 SHALL cover: write CTRL=0x1, pulse trig_i with din_valid continuous, din=incrementing from 0x100 -> STATUS=0x0400_0001 after 1024 samples, buffer word 5 reads 0x105 with ack two cycles after strobe.
REQ-029 SHALL cover: arm, software trigger (CTRL=0x4 then 0xC), 10 valid samples, CTRL=0x2 -> STATUS=0x000A_0000, busy_o 0.
REQ-030 SHALL cover: write 0x4 to STATUS -> wb_err_o pulse, wb_ack_o 0, STATUS unchanged.
REQ-031 SHALL cover: reset asserted after 300 captured samples -> STATUS reads 0x0000_0000, busy_o 0 within same cycle.
REQ-032 SHALL cover: with ADC_SNAPSHOT_TIMESTAMP_EN, trigger 500 cycles after reset release -> TSTAMP reads 500 (±1 per documented edge); without macro, read 0x8 -> wb_err_o.
REQ-033 SHALL cover: din_valid toggling every other cycle during capture -> 512 samples take 1024 cycles, word order preserved, no gaps.
